// File: rtl/trd_sched_if.sv
// Fetch-scheduler bus: redirect, spawn, kill, block/wake controls and the fetch selection.
interface trd_sched_if;
  logic        stall;
  logic        redir_vld;
  logic [2:0]  redir_trd;
  logic [31:0] redir_pc;
  logic        spawn_req;
  logic [31:0] spawn_pc;
  logic        spawn_ack;
  logic [2:0]  spawn_trd;
  logic        kill_vld;
  logic [2:0]  kill_trd;
  logic        blk_vld;
  logic [2:0]  blk_trd;
  logic        wake_vld;
  logic [2:0]  wake_trd;
  logic        fetch_vld;
  logic [2:0]  trd_fetch;
  logic [31:0] pc_fetch;
  logic [7:0]  active_mask;

  modport master (
    output stall, redir_vld, redir_trd, redir_pc, spawn_req, spawn_pc,
           kill_vld, kill_trd, blk_vld, blk_trd, wake_vld, wake_trd,
    input  spawn_ack, spawn_trd, fetch_vld, trd_fetch, pc_fetch, active_mask
  );

  modport slave (
    input  stall, redir_vld, redir_trd, redir_pc, spawn_req, spawn_pc,
           kill_vld, kill_trd, blk_vld, blk_trd, wake_vld, wake_trd,
    output spawn_ack, spawn_trd, fetch_vld, trd_fetch, pc_fetch, active_mask
  );
endinterface

// File: rtl/trd_sched.sv
// 8-thread round-robin fetch scheduler with per-thread PC table,
// spawn/kill allocation and block/wake gating.

// Per-thread slot: active/blocked flags and the thread's PC.
module trd_slot #(
  parameter bit          RST_ACT = 1'b0,
  parameter logic [31:0] RST_PC  = 32'h0,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spawn,
  input  logic [31:0] spawn_pc,
  input  logic        kill,
  input  logic        redir,
  input  logic [31:0] redir_pc,
  input  logic        adv,
  input  logic        blk,
  input  logic        wake,
  output logic        active,
  output logic        blocked,
  output logic [31:0] pc
);
  // Spawn only targets an idle slot, so it takes the whole slot; otherwise
  // kill beats redirect/block/wake, redirect beats the fetch increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= RST_ACT;
      blocked <= 1'b0;
      pc      <= RST_PC;
    end else if (spawn) begin
      active  <= 1'b1;
      blocked <= 1'b0;
      pc      <= spawn_pc;
    end else begin
      if (redir && active && !kill) pc <= redir_pc;
      else if (adv)                 pc <= pc + PC_STEP;
      if (kill) begin
        active  <= 1'b0;
        blocked <= 1'b0;
      end else if (active) begin
        if (wake)     blocked <= 1'b0;
        else if (blk) blocked <= 1'b1;
      end
    end
  end
endmodule

module trd_sched #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  trd_sched_if.slave  bus
);
  localparam int NT = 8;

  logic [NT-1:0]       active, blocked, elig;
  logic [NT-1:0][31:0] pc_tab;
  logic [2:0]          rr_ptr, sel, free_id;
  logic                any_elig, spawn_ack, adv;
  logic [NT-1:0]       spawn_hit, kill_hit, redir_hit, adv_hit, blk_hit, wake_hit;

  assign elig     = active & ~blocked;
  assign any_elig = |elig;
  assign adv      = any_elig & ~bus.stall;

  // Round-robin pick: scan rr_ptr+1 .. rr_ptr+8 (mod 8), last grant goes last.
  always_comb begin
    logic [2:0] idx;
    logic       found;
    sel   = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NT; k++) begin
      idx = rr_ptr + 3'(k);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Lowest idle thread id for spawn; 0 when every thread is busy.
  always_comb begin
    logic hit;
    free_id = '0;
    hit     = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (!hit && !active[i]) begin
        free_id = 3'(i);
        hit     = 1'b1;
      end
    end
  end

  assign spawn_ack = bus.spawn_req & ~&active;

  // Decode per-thread strobes from the thread-id buses.
  always_comb begin
    for (int i = 0; i < NT; i++) begin
      spawn_hit[i] = spawn_ack    && (free_id       == 3'(i));
      kill_hit[i]  = bus.kill_vld  && (bus.kill_trd  == 3'(i));
      redir_hit[i] = bus.redir_vld && (bus.redir_trd == 3'(i));
      adv_hit[i]   = adv           && (sel           == 3'(i));
      blk_hit[i]   = bus.blk_vld   && (bus.blk_trd   == 3'(i));
      wake_hit[i]  = bus.wake_vld  && (bus.wake_trd  == 3'(i));
    end
  end

  for (genvar i = 0; i < NT; i++) begin : g_slot
    trd_slot #(
      .RST_ACT (i == 0),
      .RST_PC  ((i == 0) ? RESET_PC : 32'h0),
      .PC_STEP (PC_STEP)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .spawn    (spawn_hit[i]),
      .spawn_pc (bus.spawn_pc),
      .kill     (kill_hit[i]),
      .redir    (redir_hit[i]),
      .redir_pc (bus.redir_pc),
      .adv      (adv_hit[i]),
      .blk      (blk_hit[i]),
      .wake     (wake_hit[i]),
      .active   (active[i]),
      .blocked  (blocked[i]),
      .pc       (pc_tab[i])
    );
  end

  // Last-grant pointer; starts at 7 so thread 0 is first after reset.
  always_ff @(posedge clk) begin
    if (rst)      rr_ptr <= 3'd7;
    else if (adv) rr_ptr <= sel;
  end

  assign bus.fetch_vld   = any_elig;
  assign bus.trd_fetch   = sel;
  assign bus.pc_fetch    = pc_tab[sel];
  assign bus.spawn_ack   = spawn_ack;
  assign bus.spawn_trd   = free_id;
  assign bus.active_mask = active;
endmodule
